// File: rtl/piso_shift_reg_tx.sv
// Parallel-in/serial-out transmitter: accepts a word over valid/ready and shifts it out MSB first.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_shift_reg_tx #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Load_valid,
    output logic             Load_ready,
    input  logic [WIDTH-1:0] Din,
    output logic             Out,
    output logic             Out_valid,
    output logic             Done
);

`ifdef PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(FLEN + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [FLEN-1:0] sr;
    logic [CW-1:0]   cnt;
    logic [FLEN-1:0] frame;
    logic            accept;

    // Parity rides as the trailing bit of the frame, so the shifter handles it like data.
`ifdef PISO_PARITY_EN
    assign frame = {Din, ^Din};
`else
    assign frame = Din;
`endif

    // The last-bit cycle reopens the load window so frames can run back to back.
    assign Load_ready = (state == IDLE) || (cnt == '0);
    assign accept     = Load_valid && Load_ready;
    assign Out        = sr[FLEN-1];

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            Out_valid <= 1'b0;
            Done      <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            sr        <= frame;
            cnt       <= CW'(FLEN - 1);
            Out_valid <= 1'b1;
            Done      <= 1'b0;
        end else if (state == SHIFT) begin
            if (cnt == '0) begin
                state     <= IDLE;
                sr        <= '0;
                Out_valid <= 1'b0;
                Done      <= 1'b0;
            end else begin
                sr   <= sr << 1;
                cnt  <= cnt - 1'b1;
                Done <= (cnt == CW'(1));
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_reg_tx.sv
// Bench for piso_shift_reg_tx: queue-of-frame-bits reference model, directed cases then random traffic.
module tb_piso_shift_reg_tx;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = W;
    localparam bit PAR = 1'b0;
`endif

    logic         Clock = 1'b0;
    logic         Resetn, Load_valid, Load_ready, Out, Out_valid, Done;
    logic [W-1:0] Din;

    always #5 Clock = ~Clock;

    piso_shift_reg_tx #(.WIDTH(W)) dut (
        .Clock(Clock), .Resetn(Resetn), .Load_valid(Load_valid), .Load_ready(Load_ready),
        .Din(Din), .Out(Out), .Out_valid(Out_valid), .Done(Done)
    );

    // Every bit still owed on the wire, oldest first; last marks the frame's final bit.
    typedef struct packed {logic b; logic last;} fbit_t;
    fbit_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic v;
        v = (q.size() > 0);
        chk("out_valid", {31'b0, Out_valid}, {31'b0, v});
        chk("out", {31'b0, Out}, {31'b0, v ? q[0].b : 1'b0});
        chk("done", {31'b0, Done}, {31'b0, v ? q[0].last : 1'b0});
        chk("load_ready", {31'b0, Load_ready}, {31'b0, q.size() <= 1});
    endtask

    task automatic push_word(input logic [W-1:0] d);
        fbit_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b    = d[i];
            e.last = (i == 0) && !PAR;
            q.push_back(e);
        end
        if (PAR) begin
            e.b    = ^d;
            e.last = 1'b1;
            q.push_back(e);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check on the falling edge.
    task automatic cycle(input logic rn, input logic lv, input logic [W-1:0] d);
        logic rdy;
        Resetn     = rn;
        Load_valid = lv;
        Din        = d;
        rdy        = (q.size() <= 1);
        @(posedge Clock);
        if (!rn) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (lv && rdy) push_word(d);
        end
        @(negedge Clock);
        check_outputs();
    endtask

    logic [FL-1:0] s;
    logic [W-1:0]  w;

    initial begin
        Resetn = 1'b0; Load_valid = 1'b1; Din = '0;

        // Reset held with Load_valid high
        cycle(1'b0, 1'b1, 4'b1010);
        cycle(1'b0, 1'b1, 4'b1010);
        chk("rst_out", {31'b0, Out}, 32'd0);
        chk("rst_valid", {31'b0, Out_valid}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        cycle(1'b1, 1'b0, 4'b0000);
        chk("ready_after_rst", {31'b0, Load_ready}, 32'd1);

        // Single word 1011
        cycle(1'b1, 1'b1, 4'b1011);
        s = '0;
        for (int i = 0; i < FL; i++) begin
            s = {s[FL-2:0], Out};
            cycle(1'b1, 1'b0, 4'b0000);
        end
        w = 4'b1011;
        chk("stream_1011", 32'(s), PAR ? 32'({w, 1'b1}) : 32'(w));
        chk("idle_after_1011", {31'b0, Out_valid}, 32'd0);

        // Busy rejection: 0011 offered during bits 1-3
        cycle(1'b1, 1'b1, 4'b1100);
        s = '0;
        for (int i = 0; i < FL; i++) begin
            s = {s[FL-2:0], Out};
            if (i < 3) chk("busy_ready", {31'b0, Load_ready}, 32'd0);
            cycle(1'b1, (i < 3), 4'b0011);
        end
        w = 4'b1100;
        chk("stream_1100", 32'(s), PAR ? 32'({w, 1'b0}) : 32'(w));

        // Back-to-back: 1001 then 0110 with Load_valid held
        cycle(1'b1, 1'b1, 4'b1001);
        for (int i = 0; i < FL - 1; i++) cycle(1'b1, 1'b1, 4'b1001);
        chk("b2b_done1", {31'b0, Done}, 32'd1);
        cycle(1'b1, 1'b1, 4'b0110);
        chk("b2b_no_gap", {31'b0, Out_valid}, 32'd1);
        for (int i = 0; i < FL; i++) cycle(1'b1, 1'b0, 4'b0000);

        // Mid-frame reset after the second bit, then 0101 cleanly
        cycle(1'b1, 1'b1, 4'b1111);
        cycle(1'b1, 1'b0, 4'b0000);
        cycle(1'b0, 1'b0, 4'b0000);
        chk("abort_valid", {31'b0, Out_valid}, 32'd0);
        chk("abort_done", {31'b0, Done}, 32'd0);
        cycle(1'b1, 1'b1, 4'b0101);
        s = '0;
        for (int i = 0; i < FL; i++) begin
            s = {s[FL-2:0], Out};
            cycle(1'b1, 1'b0, 4'b0000);
        end
        w = 4'b0101;
        chk("stream_0101", 32'(s), PAR ? 32'({w, 1'b0}) : 32'(w));

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7), W'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
